uart_lite_tx_fifo_ctrl: RTL

AXI4-Lite master that feeds an AXI UART Lite core from an internal byte FIFO.
- Bytes enter through a valid/ready stream and are buffered.
- Each byte is written to the UART TX FIFO register only after a status-register poll shows free space.
- Replaces the single-byte, non-polling TX driver. Adds buffering, a full read channel, flow control, response retry and error reporting.

---
 rtl/uart_lite_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_lite_tx_fifo_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_lite_pkg.sv
// Shared constants and state encoding for the AXI UART Lite TX feeder.
package uart_lite_pkg;

  localparam int unsigned UART_CTRL_OFFSET   = 'hC;
  localparam int unsigned UART_STAT_OFFSET   = 'h8;
  localparam int unsigned UART_TXFIFO_OFFSET = 'h4;

  localparam logic [7:0] CTRL_RST_FIFOS = 8'h03;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    INIT_WR,
    INIT_RESP,
    IDLE,
    STAT_RD,
    STAT_WAIT,
    TX_WR,
    TX_RESP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy output.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (level != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_lite_tx_fifo_ctrl.sv
// AXI4-Lite master feeding an AXI UART Lite TX FIFO from a buffered byte stream.
// Define UART_TX_STATS_EN to add the tx_count / retry_count statistics ports.
module uart_lite_tx_fifo_ctrl
  import uart_lite_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CTRL_OFFSET   = UART_CTRL_OFFSET,
  parameter int unsigned STAT_OFFSET   = UART_STAT_OFFSET,
  parameter int unsigned TXFIFO_OFFSET = UART_TXFIFO_OFFSET,
  parameter int unsigned TXFULL_BIT    = 3,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [ADDR_W-1:0]             awaddr,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [DATA_W-1:0]             wdata,
  output logic [DATA_W/8-1:0]           wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic [ADDR_W-1:0]             araddr,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [DATA_W-1:0]             rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          init_done,
  output logic                          err,
`ifdef UART_TX_STATS_EN
  output logic [31:0]                   tx_count,
  output logic [15:0]                   retry_count,
`endif
  input  logic                          err_clr
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  tx_state_e       state;
  logic [7:0]      head;
  logic            full;
  logic            push;
  logic            pop;
  logic            b_ok;
  logic            drop;
  logic            wr_done;
  logic            err_set;
  logic [RW-1:0]   retry_cnt;
  logic            unused_rdata;

  assign s_ready      = init_done && !full;
  assign push         = s_valid && s_ready;
  assign b_ok         = (bresp == RESP_OKAY);
  assign drop         = (retry_cnt >= RW'(MAX_RETRY));
  assign pop          = (state == TX_RESP) && bvalid && (b_ok || drop);
  assign err_set      = (state == TX_RESP) && bvalid && !b_ok && drop;
  // A channel is finished once its valid is low or it handshakes this cycle.
  assign wr_done      = (!awvalid || awready) && (!wvalid || wready);
  assign unused_rdata = ^rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_WR;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
      retry_cnt <= '0;
    end else begin
      wstrb <= '1;
      err   <= err_clr ? 1'b0 : (err || err_set);
      case (state)
        INIT_WR: begin
          // Both valids low here only on the first cycle out of reset.
          if (!awvalid && !wvalid) begin
            awaddr  <= ADDR_W'(CTRL_OFFSET);
            wdata   <= DATA_W'(CTRL_RST_FIFOS);
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
          end else begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
            if (wr_done) begin
              bready <= 1'b1;
              state  <= INIT_RESP;
            end
          end
        end
        INIT_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (b_ok) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= INIT_WR;
            end
          end
        end
        IDLE: begin
          if (fifo_level != '0) begin
            araddr  <= ADDR_W'(STAT_OFFSET);
            arvalid <= 1'b1;
            state   <= STAT_RD;
          end
        end
        STAT_RD: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= STAT_WAIT;
          end
        end
        STAT_WAIT: begin
          if (rvalid) begin
            rready <= 1'b0;
            if ((rresp != RESP_OKAY) || rdata[TXFULL_BIT]) begin
              state <= IDLE;
            end else begin
              awaddr  <= ADDR_W'(TXFIFO_OFFSET);
              wdata   <= DATA_W'(head);
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= TX_WR;
            end
          end
        end
        TX_WR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (wr_done) begin
            bready <= 1'b1;
            state  <= TX_RESP;
          end
        end
        TX_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (!b_ok && !drop) begin
              retry_cnt <= retry_cnt + RW'(1);
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              state     <= TX_WR;
            end else begin
              retry_cnt <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= INIT_WR;
      endcase
    end
  end

`ifdef UART_TX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count    <= '0;
      retry_count <= '0;
    end else if ((state == TX_RESP) && bvalid) begin
      if (b_ok && (tx_count != '1))         tx_count    <= tx_count + 32'd1;
      if (!b_ok && (retry_count != '1))     retry_count <= retry_count + 16'd1;
    end
  end
`endif

endmodule
